// File: rtl/efpga_cfg_wrap.sv
// eFPGA wrapper: streams a bitstream into the fabric shift chains, verifies a trailing
// additive checksum, and only then opens the registered user data path.

// Behavioural stand-in for the fabric: folds every shifted word into a config signature
// and returns it alongside the input data, so configuration and data path are observable.
module fpga #(
  parameter int V      = 2,
  parameter int H      = 3,
  parameter int PROG_W = 32,
  parameter int SHFT_W = 9,
  parameter int DIN_W  = 96,
  parameter int DOUT_W = 128
) (
  input  logic              clk,
  input  logic              nres,
  input  logic [PROG_W-1:0] prog_i,
  input  logic [SHFT_W-1:0] prog_shft,
  input  logic              data_en,
  input  logic [DIN_W-1:0]  data_in,
  output logic [DOUT_W-1:0] data_out
);
  logic [PROG_W-1:0] cfg_xor;

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      cfg_xor  <= '0;
      data_out <= '0;
    end else begin
      if (|prog_shft) cfg_xor <= cfg_xor ^ prog_i;
      data_out <= data_en ? (DOUT_W'({cfg_xor, data_in}) ^ DOUT_W'(V * H)) : '0;
    end
  end
endmodule

// state   | meaning
// IDLE    | unconfigured, waiting for cfg_start
// LOAD    | accepting bitstream words, one shift pulse per word
// CHECK   | next accepted word is the checksum
// RUN     | configured, user data path open
// ERROR   | checksum mismatch, waiting for cfg_start
module efpga_cfg_wrap #(
  parameter int V      = 2,
  parameter int H      = 3,
  parameter int PROG_W = 32,
  parameter int SHFT_W = 9,
  parameter int WORDS  = 64,
  parameter int DIN_W  = 96,
  parameter int DOUT_W = 128
) (
  input  logic              clk,
  input  logic              nres,
  input  logic              cfg_start,
  input  logic [PROG_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              cfg_done,
  output logic              cfg_err,
  input  logic              usr_en,
  input  logic [DIN_W-1:0]  usr_in,
  output logic [DOUT_W-1:0] usr_out
);
  localparam int CW = (SHFT_W > 1) ? $clog2(SHFT_W) : 1;
  localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  logic [2:0]        state;
  logic [CW-1:0]     chain_idx;
  logic [WW-1:0]     word_idx;
  logic [PROG_W-1:0] checksum;
  logic [PROG_W-1:0] prog_i;
  logic [SHFT_W-1:0] prog_shft;
  logic [SHFT_W-1:0] chain_onehot;
  logic              fab_data_en;
  logic [DIN_W-1:0]  fab_data_in;
  logic [DOUT_W-1:0] fab_data_out;
  logic              accept;
  logic              word_wrap;
  logic              last_word;
  logic              run_next;

  assign cfg_ready    = (state == S_LOAD) || (state == S_CHECK);
  assign accept       = cfg_valid & cfg_ready;
  assign word_wrap    = (word_idx == WW'(WORDS - 1));
  assign last_word    = word_wrap && (chain_idx == CW'(SHFT_W - 1));
  assign chain_onehot = SHFT_W'(1) << chain_idx;
  // A start in RUN closes the data path on the same edge that leaves RUN.
  assign run_next     = (state == S_RUN) && !cfg_start;

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state     <= S_IDLE;
      chain_idx <= '0;
      word_idx  <= '0;
      checksum  <= '0;
      cfg_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (cfg_start) begin
            state     <= S_LOAD;
            chain_idx <= '0;
            word_idx  <= '0;
            checksum  <= '0;
            cfg_err   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            checksum <= checksum + cfg_data;
            if (word_wrap) begin
              word_idx  <= '0;
              chain_idx <= chain_idx + 1'b1;
            end else begin
              word_idx <= word_idx + 1'b1;
            end
            if (last_word) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (accept) begin
            if (cfg_data == checksum) begin
              state <= S_RUN;
            end else begin
              state   <= S_ERROR;
              cfg_err <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Shift pulse follows each data-word accept by one cycle; prog_i holds between accepts.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      prog_i    <= '0;
      prog_shft <= '0;
    end else begin
      if ((state == S_LOAD) && accept) begin
        prog_i    <= cfg_data;
        prog_shft <= chain_onehot;
      end else begin
        prog_shft <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      cfg_done    <= 1'b0;
      fab_data_en <= 1'b0;
      fab_data_in <= '0;
      usr_out     <= '0;
    end else begin
      cfg_done    <= run_next;
      fab_data_en <= run_next & usr_en;
      fab_data_in <= run_next ? usr_in : '0;
      usr_out     <= run_next ? fab_data_out : '0;
    end
  end

  fpga #(
    .V      (V),
    .H      (H),
    .PROG_W (PROG_W),
    .SHFT_W (SHFT_W),
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W)
  ) u_fabric (
    .clk       (clk),
    .nres      (nres),
    .prog_i    (prog_i),
    .prog_shft (prog_shft),
    .data_en   (fab_data_en),
    .data_in   (fab_data_in),
    .data_out  (fab_data_out)
  );
endmodule

// File: tb/tb_efpga_cfg_wrap.sv
// Self-checking bench for efpga_cfg_wrap: directed and randomized bitstream loads plus
// user traffic, compared against a behavioural model of the loader and stand-in fabric.
module tb_efpga_cfg_wrap;
  localparam int V      = 2;
  localparam int H      = 3;
  localparam int PROG_W = 32;
  localparam int SHFT_W = 3;
  localparam int WORDS  = 2;
  localparam int DIN_W  = 96;
  localparam int DOUT_W = 128;
  localparam int NW     = SHFT_W * WORDS;

  logic              clk = 1'b0;
  logic              nres;
  logic              cfg_start;
  logic [PROG_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_done;
  logic              cfg_err;
  logic              usr_en;
  logic [DIN_W-1:0]  usr_in;
  logic [DOUT_W-1:0] usr_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_xor;
  logic [31:0] wbuf [NW];
  logic [31:0] last_prog;

  efpga_cfg_wrap #(
    .V(V), .H(H), .PROG_W(PROG_W), .SHFT_W(SHFT_W), .WORDS(WORDS),
    .DIN_W(DIN_W), .DOUT_W(DOUT_W)
  ) dut (
    .clk       (clk),
    .nres      (nres),
    .cfg_start (cfg_start),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .usr_en    (usr_en),
    .usr_in    (usr_in),
    .usr_out   (usr_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    check_eq("start_ready", cfg_ready, 1);
    check_eq("start_done_clr", cfg_done, 0);
    check_eq("start_err_clr", cfg_err, 0);
  endtask

  // mode 0: back-to-back, 1: valid toggles 1/0, 2: random stalls
  task automatic load(input logic [31:0] csum, input int mode, output bit good);
    logic [31:0] sum;
    logic [31:0] data;
    bit v;
    bit ph;
    int tries;
    sum = 0;
    ph = 1'b1;
    for (int i = 0; i <= NW; i++) begin
      data = (i < NW) ? wbuf[i] : csum;
      tries = 0;
      do begin
        case (mode)
          0:       v = 1'b1;
          1:       v = ph;
          default: v = ($urandom_range(0, 1) == 1) || (tries > 20);
        endcase
        ph = ~ph;
        cfg_valid = v;
        cfg_data  = v ? data : $urandom;
        check_eq("ready_load", cfg_ready, 1);
        step();
        if (v) begin
          if (i < NW) begin
            check_eq("shft_pulse", dut.prog_shft, 128'(1) << (i / WORDS));
            check_eq("prog_i", dut.prog_i, data);
            m_xor ^= data;
            sum += data;
            last_prog = data;
          end else begin
            check_eq("csum_no_shft", dut.prog_shft, 0);
          end
        end else begin
          check_eq("stall_shft", dut.prog_shft, 0);
          check_eq("stall_prog_i_hold", dut.prog_i, last_prog);
        end
        tries++;
      end while (!v);
    end
    cfg_valid = 1'b0;
    good = (sum == csum);
    check_eq("done_early", cfg_done, 0);
    step();
    check_eq("done", cfg_done, good);
    check_eq("err", cfg_err, !good);
    check_eq("ready_after", cfg_ready, 0);
  endtask

  // Expects RUN entered with an empty data pipeline.
  task automatic traffic(input int n, input bit directed);
    bit en, en_d;
    logic [DIN_W-1:0] in, in_d;
    logic [DOUT_W-1:0] fo, uo;
    en_d = 0; in_d = '0; fo = '0; uo = '0;
    for (int k = 0; k < n; k++) begin
      en = ($urandom_range(0, 1) == 1);
      in = {$urandom, $urandom, $urandom};
      if (directed && k == 0) begin
        en = 1'b1;
        in = 96'h123;
      end
      usr_en = en;
      usr_in = in;
      step();
      uo = fo;
      fo = en_d ? ({m_xor, in_d} ^ 128'(V * H)) : '0;
      en_d = en;
      in_d = in;
      check_eq("fab_en", dut.fab_data_en, en);
      check_eq("fab_in", dut.fab_data_in, in);
      check_eq("fab_out", dut.fab_data_out, fo);
      check_eq("usr_out", usr_out, uo);
    end
    usr_en = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NW; i++) wbuf[i] = $urandom;
  endtask

  function automatic logic [31:0] buf_sum();
    logic [31:0] s;
    s = 0;
    for (int i = 0; i < NW; i++) s += wbuf[i];
    return s;
  endfunction

  initial begin
    bit good;
    nres = 1'b0; cfg_start = 0; cfg_valid = 0; cfg_data = '0; usr_en = 0; usr_in = '0;
    m_xor = 0; last_prog = 0;
    step(); step();
    check_eq("rst_ready", cfg_ready, 0);
    check_eq("rst_done", cfg_done, 0);
    check_eq("rst_err", cfg_err, 0);
    check_eq("rst_usr_out", usr_out, 0);
    check_eq("rst_shft", dut.prog_shft, 0);
    nres = 1'b1;
    step();
    check_eq("idle_ready", cfg_ready, 0);

    // clean load, then directed run traffic
    for (int i = 0; i < NW; i++) wbuf[i] = i + 1;
    pulse_start();
    load(32'h15, 0, good);
    traffic(12, 1'b1);

    // restart from RUN must immediately close the data path
    usr_en = 1'b1; usr_in = {$urandom, $urandom, $urandom};
    pulse_start();
    check_eq("restart_fab_en", dut.fab_data_en, 0);
    check_eq("restart_usr_out", usr_out, 0);
    usr_en = 1'b0;

    // stalled load with toggling valid
    load(32'h15, 1, good);
    traffic(10, 1'b0);

    // bad checksum
    pulse_start();
    load(32'h16, 0, good);
    usr_en = 1'b1; usr_in = 96'hA5;
    step(); step();
    check_eq("err_fab_en", dut.fab_data_en, 0);
    check_eq("err_usr_out", usr_out, 0);
    check_eq("err_held", cfg_err, 1);
    check_eq("err_ready", cfg_ready, 0);
    usr_en = 1'b0;
    pulse_start();

    // reset mid-load after three accepted words
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1; cfg_data = i + 1;
      step();
    end
    cfg_valid = 1'b0;
    #2 nres = 1'b0;
    #1;
    m_xor = 0; last_prog = 0;
    check_eq("mid_rst_ready", cfg_ready, 0);
    check_eq("mid_rst_done", cfg_done, 0);
    check_eq("mid_rst_err", cfg_err, 0);
    check_eq("mid_rst_usr_out", usr_out, 0);
    check_eq("mid_rst_shft", dut.prog_shft, 0);
    check_eq("mid_rst_prog_i", dut.prog_i, 0);
    step();
    nres = 1'b1;
    step();
    check_eq("post_rst_ready", cfg_ready, 0);
    fill_random();
    pulse_start();
    load(buf_sum(), 0, good);
    traffic(8, 1'b0);

    // checksum wraps modulo 2^32
    for (int i = 0; i < NW - 1; i++) wbuf[i] = 32'hFFFF_FFFF;
    wbuf[NW-1] = 32'h6;
    pulse_start();
    load(32'h1, 0, good);
    traffic(6, 1'b0);

    // randomized loads with random stalls and occasional corrupt checksum
    for (int r = 0; r < 6; r++) begin
      logic [31:0] cs;
      fill_random();
      cs = buf_sum();
      if ($urandom_range(0, 2) == 0) cs = cs ^ (32'h1 << $urandom_range(0, 31));
      pulse_start();
      load(cs, 2, good);
      if (good) traffic(8, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
